// File: rtl/dt_arbiter.sv
// dt_arbiter: round-robin arbiter sharing one domain-transform converter between two requesters
module dt_arbiter #(
   parameter int TIMEOUT = 40
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic        mont0,
   input  logic        mont1,
   input  logic [31:0] px0,
   input  logic [31:0] py0,
   input  logic [31:0] px1,
   input  logic [31:0] py1,
   output logic        ack0,
   output logic        ack1,
   output logic [31:0] rsp_px,
   output logic [31:0] rsp_py,
   output logic        rsp_err,
   output logic        dt_in_sig,
   output logic        dt_to_mont,
   output logic [31:0] dt_px,
   output logic [31:0] dt_py,
   input  logic        dt_done,
   input  logic [31:0] dt_px_out,
   input  logic [31:0] dt_py_out
);
   localparam int CW = ($clog2(TIMEOUT + 1) > 6) ? $clog2(TIMEOUT + 1) : 6;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t        state, next;
   logic [CW-1:0] cnt;
   logic          grant, prio, pick, timeout;

   // prio names the requester that wins a tie; a lone request always wins
   assign pick      = (req0 & req1) ? prio : req1;
   // compare the value the counter is about to hold so the error ack lands at grant+1+TIMEOUT
   assign timeout   = (cnt + 1'b1) == CW'(TIMEOUT - 1);
   assign dt_in_sig = state == ISSUE;
   assign ack0      = (state == RESP) & ~grant;
   assign ack1      = (state == RESP) & grant;

   // state register
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= next;
   end

   // next-state decode; dt_done only matters while waiting
   always_comb begin
      next = state;
      case (state)
         IDLE:    if (req0 | req1) next = ISSUE;
         ISSUE:   next = WAIT;
         WAIT:    if (dt_done | timeout) next = RESP;
         RESP:    next = IDLE;
         default: next = IDLE;
      endcase
   end

   // grant latch, timeout counter, response capture and round-robin pointer
   always_ff @(posedge clk) begin
      if (!reset) begin
         grant      <= 1'b0;
         prio       <= 1'b0;
         cnt        <= '0;
         dt_to_mont <= 1'b0;
         dt_px      <= '0;
         dt_py      <= '0;
         rsp_px     <= '0;
         rsp_py     <= '0;
         rsp_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req0 | req1) begin
               grant      <= pick;
               dt_to_mont <= pick ? mont1 : mont0;
               dt_px      <= pick ? px1 : px0;
               dt_py      <= pick ? py1 : py0;
            end
            ISSUE: cnt <= '0;
            WAIT: begin
               cnt <= cnt + 1'b1;
               if (dt_done) begin
                  rsp_px  <= dt_px_out;
                  rsp_py  <= dt_py_out;
                  rsp_err <= 1'b0;
               end else if (timeout) begin
                  rsp_px  <= '0;
                  rsp_py  <= '0;
                  rsp_err <= 1'b1;
               end
            end
            RESP: prio <= ~grant;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_dt_arbiter.sv
// tb_dt_arbiter: scoreboard bench with a converter model for dt_arbiter
module tb_dt_arbiter;
   localparam int T = 40;

   logic        clk, reset, req0, req1, mont0, mont1;
   logic [31:0] px0, py0, px1, py1;
   logic        ack0, ack1, rsp_err, dt_in_sig, dt_to_mont, dt_done;
   logic [31:0] rsp_px, rsp_py, dt_px, dt_py, dt_px_out, dt_py_out;

   typedef struct {
      logic [31:0] id, mont, px, py, rpx, rpy, err, lat;
      int          delay;
   } exp_t;

   exp_t q[$];
   int   vectors = 0, miscompares = 0;
   int   cyc = 0, issue_cyc = 0, done_at = -1, n_ack = 0;
   bit   busy = 0;
   logic [31:0] done_px, done_py;

   dt_arbiter #(.TIMEOUT(T)) dut (
      .clk(clk), .reset(reset), .req0(req0), .req1(req1), .mont0(mont0), .mont1(mont1),
      .px0(px0), .py0(py0), .px1(px1), .py1(py1), .ack0(ack0), .ack1(ack1),
      .rsp_px(rsp_px), .rsp_py(rsp_py), .rsp_err(rsp_err), .dt_in_sig(dt_in_sig),
      .dt_to_mont(dt_to_mont), .dt_px(dt_px), .dt_py(dt_py), .dt_done(dt_done),
      .dt_px_out(dt_px_out), .dt_py_out(dt_py_out)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // the converter doubles each operand; results are valid only when dt_done lands before the timeout
   function automatic void push(input int id, input bit m, input logic [31:0] x, input logic [31:0] y, input int d);
      exp_t e;
      bit   ok;
      ok      = d > 0 && d < T;
      e.id    = 32'(id);
      e.mont  = 32'(m);
      e.px    = x;
      e.py    = y;
      e.delay = d;
      e.rpx   = ok ? {x[30:0], 1'b0} : 32'h0;
      e.rpy   = ok ? {y[30:0], 1'b0} : 32'h0;
      e.err   = ok ? 32'h0 : 32'h1;
      e.lat   = ok ? 32'(d + 1) : 32'(T);
      q.push_back(e);
   endfunction

   // converter model plus monitor, sampling mid-cycle
   always @(negedge clk) begin
      exp_t e;
      dt_done = 1'b0;
      if (done_at == cyc) begin
         dt_done   = 1'b1;
         dt_px_out = done_px;
         dt_py_out = done_py;
      end
      if (dt_in_sig) begin
         check("dt_in_once", 32'(busy), 32'h0);
         if (q.size() == 0) check("dt_in_unexpected", 32'h1, 32'h0);
         else begin
            e = q[0];
            check("dt_px", dt_px, e.px);
            check("dt_py", dt_py, e.py);
            check("dt_to_mont", 32'(dt_to_mont), e.mont);
            issue_cyc = cyc;
            busy      = 1;
            if (e.delay > 0) begin
               done_at = cyc + e.delay;
               done_px = {e.px[30:0], 1'b0};
               done_py = {e.py[30:0], 1'b0};
            end
         end
      end
      if (ack0 | ack1) begin
         check("ack_both", 32'(ack0 & ack1), 32'h0);
         if (q.size() == 0) check("spurious_ack", 32'h1, 32'h0);
         else begin
            e = q.pop_front();
            check("ack_id", 32'(ack1), e.id);
            check("rsp_px", rsp_px, e.rpx);
            check("rsp_py", rsp_py, e.rpy);
            check("rsp_err", 32'(rsp_err), e.err);
            check("latency", 32'(cyc - issue_cyc), e.lat);
            check("dt_px_hold", dt_px, e.px);
         end
         busy = 0;
         n_ack++;
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_ack0", 32'(ack0), 32'h0);
      check("rst_ack1", 32'(ack1), 32'h0);
      check("rst_dt_in", 32'(dt_in_sig), 32'h0);
      check("rst_err", 32'(rsp_err), 32'h0);
      check("rst_mont", 32'(dt_to_mont), 32'h0);
      check("rst_rsp_px", rsp_px, 32'h0);
      check("rst_rsp_py", rsp_py, 32'h0);
      check("rst_dt_px", dt_px, 32'h0);
      check("rst_dt_py", dt_py, 32'h0);
   endtask

   // one operation; with drop set the request and operands are disturbed once the converter starts
   task automatic op(input int id, input bit m, input logic [31:0] x, input logic [31:0] y, input int d, input bit drop);
      int n0;
      n0 = n_ack;
      if (id == 0) begin mont0 = m; px0 = x; py0 = y; req0 = 1; end
      else         begin mont1 = m; px1 = x; py1 = y; req1 = 1; end
      push(id, m, x, y, d);
      for (int i = 0; i < 200 && n_ack == n0; i++) begin
         tick(1);
         if (drop && busy) begin
            req0 = 0; req1 = 0;
            px0 = ~x; py0 = ~y; px1 = ~x; py1 = ~y; mont0 = ~m; mont1 = ~m;
         end
      end
      if (n_ack == n0) check("ack_wait", 32'h0, 32'h1);
      req0 = 0;
      req1 = 0;
      tick(1);
   endtask

   initial begin
      int n0;
      reset = 0; req0 = 0; req1 = 0; mont0 = 0; mont1 = 0;
      px0 = 0; py0 = 0; px1 = 0; py1 = 0; dt_done = 0; dt_px_out = 0; dt_py_out = 0;
      tick(3);
      check_reset_outputs();
      reset = 1;
      tick(1);

      op(0, 1, 32'h5, 32'h7, 33, 0);
      op(1, 0, 32'h1234_5678, 32'h0BAD_F00D, 1, 0);
      op(1, 1, 32'hDEAD_BEEF, 32'hCAFE_0001, -1, 0);
      op(0, 0, 32'h0000_0101, 32'h7FFF_FFFF, 4, 0);
      op(0, 1, 32'h0F0F_0F0F, 32'h3333_3333, T - 1, 0);
      op(1, 0, 32'h2222_2222, 32'h4444_4444, T, 0);
      op(0, 1, 32'h0000_ABCD, 32'h0000_1357, 6, 1);
      for (int i = 0; i < 4; i++)
         op(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
            int'($urandom_range(1, T + 2)), 0);

      // reset in the middle of WAIT: the pending op and the later dt_done must vanish
      mont0 = 1; px0 = 32'h0000_0999; py0 = 32'h0000_0777; req0 = 1;
      push(0, 1, px0, py0, 20);
      for (int i = 0; i < 20 && !busy; i++) tick(1);
      check("mid_issue_seen", 32'(busy), 32'h1);
      for (int i = 0; i < 20 && cyc < issue_cyc + 11; i++) tick(1);
      reset = 0;
      req0  = 0;
      tick(1);
      check_reset_outputs();
      q.delete();
      busy  = 0;
      reset = 1;
      n0    = n_ack;
      tick(30);
      check("mid_no_ack", 32'(n_ack - n0), 32'h0);
      check("mid_stray_px", rsp_px, 32'h0);

      // both requesting from reset release: grants alternate starting with requester 0
      reset = 0;
      mont0 = 0; px0 = 32'h0000_1000; py0 = 32'h0000_2000;
      mont1 = 1; px1 = 32'h0000_3000; py1 = 32'h0000_4000;
      req0 = 1; req1 = 1;
      tick(1);
      push(0, 0, px0, py0, 3);
      push(1, 1, px1, py1, 5);
      push(0, 0, px0, py0, 7);
      push(1, 1, px1, py1, 2);
      n0    = n_ack;
      reset = 1;
      for (int i = 0; i < 400 && n_ack < n0 + 4; i++) tick(1);
      req0 = 0; req1 = 0;
      check("rr_acks", 32'(n_ack - n0), 32'h4);
      tick(5);
      check("queue_drained", 32'(q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
